// File: rtl/scc_mem_pkg.sv
// Shared types and defaults for the SCC memory arbiter.
package scc_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    // Saturating 32-bit increment for the optional stall counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/scc_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals of the SCC memory arbiter.
// SCC_ARB_PERF_EN adds the two stall counter outputs.
interface scc_mem_arbiter_if
    import scc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              proto_err;
`ifdef SCC_ARB_PERF_EN
    logic [31:0]       if_stall_cnt;
    logic [31:0]       d_stall_cnt;
`endif

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, proto_err
`ifdef SCC_ARB_PERF_EN
        , output if_stall_cnt, d_stall_cnt
`endif
    );

    // Core and memory view.
    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, proto_err
`ifdef SCC_ARB_PERF_EN
        , input if_stall_cnt, d_stall_cnt
`endif
    );

endinterface

// File: rtl/scc_lat_counter.sv
// Memory latency counter: loads MEM_LAT-1, counts down to zero, flags completion.
module scc_lat_counter
    import scc_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done_c
);

    logic [LAT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT_CNT_W'(MEM_LAT - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LAT_CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/scc_mem_arbiter.sv
// SCC memory arbiter: data-priority FSM sequencing fetch and load/store onto one memory port.
// Optional SCC_ARB_PERF_EN adds saturating per-port stall counters.
module scc_mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    scc_mem_arbiter_if.slave bus
);

    arb_state_e        state, state_d;
    owner_e            owner, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              proto_err_q, proto_err_d;
    logic              d_req_c, take_d, take_f;
    logic              cnt_load, cnt_dec, cnt_done_c;

    assign d_req_c = bus.d_rd | bus.d_wr;

    scc_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .done_c (cnt_done_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        proto_err_d = 1'b0;
        take_d      = 1'b0;
        take_f      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state)
            IDLE: begin
                take_d = d_req_c;
                take_f = bus.if_req & ~d_req_c;
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_done_c) begin
                    state_d = RESP;
                    if (owner == DATA) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                // The finishing port still holds its request here; only the other port may start.
                state_d = IDLE;
                take_d  = (owner == FETCH) & d_req_c;
                take_f  = (owner == DATA) & bus.if_req;
            end
            default: state_d = IDLE;
        endcase

        if (take_d) begin
            state_d     = ISSUE;
            owner_d     = DATA;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.d_wr;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            proto_err_d = bus.d_rd & bus.d_wr;
        end else if (take_f) begin
            state_d    = ISSUE;
            owner_d    = FETCH;
            mem_en_d   = 1'b1;
            mem_addr_d = bus.if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= FETCH;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.proto_err = proto_err_q;

`ifdef SCC_ARB_PERF_EN
    logic [31:0] if_stall_q, d_stall_q;

    // A cycle stalls when the port requests and its ack is not yet up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            if_stall_q <= sat_inc32(if_stall_q, bus.if_req & ~if_ack_q);
            d_stall_q  <= sat_inc32(d_stall_q, d_req_c & ~d_ack_q);
        end
    end

    assign bus.if_stall_cnt = if_stall_q;
    assign bus.d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: three instances (MEM_LAT 1, 3, 4) checked against issue/ack scoreboards.
// Build with SCC_ARB_PERF_EN defined to also check the stall counters.
module tb_scc_mem_arbiter;

    localparam int NDUT = 3;
    localparam logic [31:0] MEM_KEY = 32'hE3A0_1001;

    typedef struct packed {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        proto;
    } iss_t;

    typedef struct packed {
        int          cyc;
        logic        is_data;
        logic        chk;
        logic [31:0] rdata;
    } ack_t;

    logic clk;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        rst_n_a   [NDUT];
    logic        if_req_a  [NDUT];
    logic [31:0] if_addr_a [NDUT];
    logic        d_rd_a    [NDUT];
    logic        d_wr_a    [NDUT];
    logic [31:0] d_addr_a  [NDUT];
    logic [31:0] d_wdata_a [NDUT];
    logic        if_ack_a  [NDUT];
    logic        d_ack_a   [NDUT];
    logic [31:0] if_rdata_a[NDUT];
    logic [31:0] d_rdata_a [NDUT];
    logic        mem_en_a  [NDUT];
    logic        mem_we_a  [NDUT];
    logic [31:0] mem_addr_a[NDUT];
    logic        proto_a   [NDUT];
`ifdef SCC_ARB_PERF_EN
    logic [31:0] if_stall_a[NDUT];
    logic [31:0] d_stall_a [NDUT];
`endif

    iss_t iss_q[NDUT][$];
    ack_t ack_q[NDUT][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        scc_mem_arbiter_if bus ();
        int unsigned m_cnt  = 0;
        logic [31:0] m_addr = '0;

        scc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
            .clk   (clk),
            .reset (rst_n_a[g]),
            .bus   (bus)
        );

        assign bus.if_req   = if_req_a[g];
        assign bus.if_addr  = if_addr_a[g];
        assign bus.d_rd     = d_rd_a[g];
        assign bus.d_wr     = d_wr_a[g];
        assign bus.d_addr   = d_addr_a[g];
        assign bus.d_wdata  = d_wdata_a[g];
        assign if_ack_a[g]   = bus.if_ack;
        assign d_ack_a[g]    = bus.d_ack;
        assign if_rdata_a[g] = bus.if_rdata;
        assign d_rdata_a[g]  = bus.d_rdata;
        assign mem_en_a[g]   = bus.mem_en;
        assign mem_we_a[g]   = bus.mem_we;
        assign mem_addr_a[g] = bus.mem_addr;
        assign proto_a[g]    = bus.proto_err;
`ifdef SCC_ARB_PERF_EN
        assign if_stall_a[g] = bus.if_stall_cnt;
        assign d_stall_a[g]  = bus.d_stall_cnt;
`endif

        // Memory model: read data is valid only for the edge LAT cycles after mem_en is sampled.
        always @(posedge clk) begin
            if (bus.mem_en) begin
                m_cnt  <= LAT;
                m_addr <= bus.mem_addr;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
        assign bus.mem_rdata = (m_cnt == 1) ? (m_addr ^ MEM_KEY) : 32'hBAD0_BAD0;

        always @(negedge clk) begin : mon
            iss_t ei;
            ack_t ea;
            check($sformatf("dut%0d ack overlap", g), 64'(bus.if_ack & bus.d_ack), 64'd0);
            check($sformatf("dut%0d mem_we without mem_en", g), 64'(bus.mem_we & ~bus.mem_en), 64'd0);
            check($sformatf("dut%0d proto_err outside issue", g), 64'(bus.proto_err & ~bus.mem_en), 64'd0);
            if (bus.mem_en) begin
                check($sformatf("dut%0d issue expected", g), 64'(iss_q[g].size() != 0), 64'd1);
                if (iss_q[g].size() != 0) begin
                    ei = iss_q[g].pop_front();
                    check($sformatf("dut%0d issue cycle", g), 64'(cyc), 64'(ei.cyc));
                    check($sformatf("dut%0d mem_we", g), 64'(bus.mem_we), 64'(ei.we));
                    check($sformatf("dut%0d mem_addr", g), 64'(bus.mem_addr), 64'(ei.addr));
                    check($sformatf("dut%0d proto_err", g), 64'(bus.proto_err), 64'(ei.proto));
                    if (ei.we) check($sformatf("dut%0d mem_wdata", g), 64'(bus.mem_wdata), 64'(ei.wdata));
                end
            end
            if (bus.if_ack || bus.d_ack) begin
                check($sformatf("dut%0d ack expected", g), 64'(ack_q[g].size() != 0), 64'd1);
                if (ack_q[g].size() != 0) begin
                    ea = ack_q[g].pop_front();
                    check($sformatf("dut%0d ack cycle", g), 64'(cyc), 64'(ea.cyc));
                    check($sformatf("dut%0d ack port {if,d}", g), 64'({bus.if_ack, bus.d_ack}),
                          ea.is_data ? 64'd1 : 64'd2);
                    if (ea.chk)
                        check($sformatf("dut%0d rdata", g),
                              64'(ea.is_data ? bus.d_rdata : bus.if_rdata), 64'(ea.rdata));
                end
            end
        end
    end

    task automatic push_iss(input int d, input int at, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic proto);
        iss_t e;
        e.cyc = at; e.we = we; e.addr = addr; e.wdata = wdata; e.proto = proto;
        iss_q[d].push_back(e);
    endtask

    task automatic push_ack(input int d, input int at, input logic is_data, input logic chk,
                            input logic [31:0] rdata);
        ack_t e;
        e.cyc = at; e.is_data = is_data; e.chk = chk; e.rdata = rdata;
        ack_q[d].push_back(e);
    endtask

    // Requesters drop their request as soon as they see their ack.
    task automatic run_until_done(input int d, input int budget);
        int n = 0;
        while ((if_req_a[d] || d_rd_a[d] || d_wr_a[d]) && (n < budget)) begin
            @(negedge clk);
            n++;
            if (if_ack_a[d]) if_req_a[d] = 1'b0;
            if (d_ack_a[d]) begin
                d_rd_a[d] = 1'b0;
                d_wr_a[d] = 1'b0;
            end
        end
        check($sformatf("dut%0d requests completed within %0d cycles", d, budget),
              64'(if_req_a[d] | d_rd_a[d] | d_wr_a[d]), 64'd0);
    endtask

    task automatic check_cleared(input int d, input string tag);
        check($sformatf("dut%0d %s strobes/acks", d, tag),
              64'({mem_en_a[d], mem_we_a[d], if_ack_a[d], d_ack_a[d], proto_a[d]}), 64'd0);
        check($sformatf("dut%0d %s mem_addr", d, tag), 64'(mem_addr_a[d]), 64'd0);
        check($sformatf("dut%0d %s if_rdata", d, tag), 64'(if_rdata_a[d]), 64'd0);
        check($sformatf("dut%0d %s d_rdata", d, tag), 64'(d_rdata_a[d]), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
`ifdef SCC_ARB_PERF_EN
        logic [31:0] if_s0, d_s0;
`endif
        for (int i = 0; i < NDUT; i++) begin
            rst_n_a[i] = 1'b0; if_req_a[i] = 1'b0; if_addr_a[i] = '0;
            d_rd_a[i] = 1'b0; d_wr_a[i] = 1'b0; d_addr_a[i] = '0; d_wdata_a[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) check_cleared(i, "in reset");
        for (int i = 0; i < NDUT; i++) rst_n_a[i] = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch only, MEM_LAT=1.
        @(negedge clk); c = cyc;
        if_req_a[0] = 1'b1; if_addr_a[0] = 32'h0000_0004;
        push_iss(0, c + 1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        push_ack(0, c + 3, 1'b0, 1'b1, 32'hE3A0_1005);
        run_until_done(0, 20);

        // Write, MEM_LAT=3.
        @(negedge clk); c = cyc;
        d_wr_a[1] = 1'b1; d_addr_a[1] = 32'h100; d_wdata_a[1] = 32'hDEAD_BEEF;
        push_iss(1, c + 1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        push_ack(1, c + 5, 1'b1, 1'b0, 32'h0);
        run_until_done(1, 20);

        // Contention, MEM_LAT=1: data first, fetch on the edge leaving RESP.
        @(negedge clk); c = cyc;
`ifdef SCC_ARB_PERF_EN
        if_s0 = if_stall_a[0]; d_s0 = d_stall_a[0];
`endif
        if_req_a[0] = 1'b1; if_addr_a[0] = 32'h8;
        d_rd_a[0] = 1'b1; d_addr_a[0] = 32'h200;
        push_iss(0, c + 1, 1'b0, 32'h200, 32'h0, 1'b0);
        push_ack(0, c + 3, 1'b1, 1'b1, 32'h200 ^ MEM_KEY);
        push_iss(0, c + 4, 1'b0, 32'h8, 32'h0, 1'b0);
        push_ack(0, c + 6, 1'b0, 1'b1, 32'h8 ^ MEM_KEY);
        run_until_done(0, 30);
        @(negedge clk);
`ifdef SCC_ARB_PERF_EN
        check("dut0 if_stall_cnt delta", 64'(if_stall_a[0] - if_s0), 64'd6);
        check("dut0 d_stall_cnt delta", 64'(d_stall_a[0] - d_s0), 64'd3);
`endif

        // Protocol error, MEM_LAT=3: handled as a write.
        @(negedge clk); c = cyc;
        d_rd_a[1] = 1'b1; d_wr_a[1] = 1'b1; d_addr_a[1] = 32'h40; d_wdata_a[1] = 32'h1234_5678;
        push_iss(1, c + 1, 1'b1, 32'h40, 32'h1234_5678, 1'b1);
        push_ack(1, c + 5, 1'b1, 1'b0, 32'h0);
        run_until_done(1, 20);

        // MEM_LAT=4: one normal fetch, then one aborted by reset in WAIT.
        @(negedge clk); c = cyc;
        if_req_a[2] = 1'b1; if_addr_a[2] = 32'h20;
        push_iss(2, c + 1, 1'b0, 32'h20, 32'h0, 1'b0);
        push_ack(2, c + 6, 1'b0, 1'b1, 32'h20 ^ MEM_KEY);
        run_until_done(2, 20);
        @(negedge clk); c = cyc;
        if_req_a[2] = 1'b1; if_addr_a[2] = 32'h44;
        push_iss(2, c + 1, 1'b0, 32'h44, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n_a[2] = 1'b0;
        if_req_a[2] = 1'b0;
        #1 check_cleared(2, "after async reset");
        repeat (2) @(negedge clk);
        rst_n_a[2] = 1'b1;
        repeat (2) @(negedge clk);
        c = cyc;
        if_req_a[2] = 1'b1; if_addr_a[2] = 32'h10;
        push_iss(2, c + 1, 1'b0, 32'h10, 32'h0, 1'b0);
        push_ack(2, c + 6, 1'b0, 1'b1, 32'h10 ^ MEM_KEY);
        run_until_done(2, 20);

        repeat (8) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d pending issues", i), 64'(iss_q[i].size()), 64'd0);
            check($sformatf("dut%0d pending acks", i), 64'(ack_q[i].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scc_mem_arbiter.md
Name: scc_mem_arbiter

Overview:
- Sequences a single-port synchronous memory shared between the SCC instruction-fetch port and its data load/store port.
- Sits between the SCC core and the unified memory model.
- Each transaction is issued by a small FSM, its fixed memory latency is counted, and it completes with a one-cycle ack.
- Data accesses have priority over fetches.

Parameters:
- ADDR_W, 32: address width, byte addresses passed through unchanged.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from mem_en sampled by memory to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- d_rd  in  1  data read request; held until d_ack.
- d_wr  in  1  data write request; held until d_ack.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  read data; valid while d_ack=1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- proto_err  out  1  one-cycle pulse: d_rd and d_wr both high when accepted.

Behaviour:
- Reset (asynchronous, while reset=0): state IDLE, cnt=0, owner=FETCH, all outputs 0 including data buses. Reset asserted mid-transaction aborts it at once: mem_en drops, no ack is issued.
- Registers: all outputs are registered. Read data is captured from mem_rdata into if_rdata/d_rdata and held until the next capture.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on a rising edge with (d_rd|d_wr)=1, owner=DATA and mem_en, mem_we=d_wr, mem_addr=d_addr, mem_wdata=d_wdata are registered; go to ISSUE. Otherwise, if if_req=1: owner=FETCH, mem_we=0, mem_addr=if_addr; go to ISSUE. With no request, stay.
- ISSUE (mem_en=1 for exactly this cycle): next edge clears mem_en and mem_we, loads cnt=MEM_LAT-1, goes to WAIT.
- WAIT: each edge decrements cnt. At the edge where cnt==0: capture mem_rdata into the owner's rdata (also for writes, value don't-care), raise the owner's ack, go to RESP.
- RESP (ack=1 for exactly this cycle): requests are ignored. Next edge drops ack and goes to IDLE.
- Latency: acceptance edge to ack rising = MEM_LAT+1 cycles. Occupancy is MEM_LAT+2 cycles per transaction; back-to-back requests accept on the edge leaving RESP.
- Simultaneous if_req and data request in IDLE: data wins; the fetch is accepted at the next IDLE.
- d_rd=d_wr=1 at acceptance: handled as a write, proto_err pulses during ISSUE.
- Request withdrawn before ack: the transaction still completes and acks; the requester must ignore it.
- mem_addr and mem_wdata hold their last values after ISSUE until the next acceptance.
- The two acks are never high in the same cycle.

Optional Feature:
- Macro SCC_ARB_PERF_EN.
- Defined: adds outputs if_stall_cnt[31:0] and d_stall_cnt[31:0]. Each counts cycles where its request is high and its ack is low. Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent and the logic is identical otherwise.

Decomposition:
- Shared package scc_mem_pkg: state enum (IDLE, ISSUE, WAIT, RESP), owner enum (FETCH, DATA), defaults for ADDR_W/DATA_W, LAT_CNT_W=4.
- One natural sub-module, scc_lat_counter: load MEM_LAT-1, decrement, done flag. The FSM stays in the top.

Test Plan:
- Fetch only, MEM_LAT=1: if_req=1, if_addr=32'h0000_0004, memory returns 32'hE3A0_1005 → mem_en high one cycle with mem_addr=4, mem_we=0; if_ack 2 cycles after acceptance with if_rdata=32'hE3A0_1005.
- Write, MEM_LAT=3: d_wr=1, d_addr=32'h100, d_wdata=32'hDEAD_BEEF → mem_we=1 for one cycle with matching addr/wdata; d_ack 4 cycles after acceptance; if_ack stays 0.
- Contention: if_req and d_rd raised in the same cycle, addresses 0x8 and 0x200 → data is issued first (mem_addr=0x200); fetch issued on the edge leaving RESP (mem_addr=0x8); two acks, never overlapping.
- Protocol error: d_rd=d_wr=1, d_addr=0x40 → treated as a write (mem_we=1), proto_err pulses once.
- Reset mid-WAIT, MEM_LAT=4: assert reset 2 cycles after acceptance → mem_en, acks and rdata are 0 immediately; after release the FSM is IDLE and the next if_req completes normally.
- SCC_ARB_PERF_EN defined: fetch blocked behind one data op at MEM_LAT=1 → if_stall_cnt increments by exactly 6 (3 blocked plus 3 own cycles before ack).
